// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the cache RAM write-port arbiter.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CORE_WAIT,
    FILL,
    FILL_WAIT
  } arb_state_e;

  localparam int unsigned DEFAULT_BYTE_NUM = 4;
  localparam logic [DEFAULT_BYTE_NUM-1:0] FULL_BE = '1;

  function automatic int unsigned LINE_IDX_W(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/cache_ram_arbiter_if.sv
// Core store, refill, core read and RAM port bundle of the cache RAM arbiter.
interface cache_ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_BYTE_NUM = 4
);
  logic                     core_wr_req;
  logic [ADDR_WIDTH-1:0]    core_wr_addr;
  logic [DATA_WIDTH-1:0]    core_wr_data;
  logic [DATA_BYTE_NUM-1:0] core_wr_be;
  logic                     core_wr_ack;

  logic                     fill_start;
  logic [ADDR_WIDTH-1:0]    fill_base_addr;
  logic                     fill_valid;
  logic [DATA_WIDTH-1:0]    fill_data;
  logic                     fill_ready;
  logic                     fill_busy;
  logic                     fill_done;

  logic [ADDR_WIDTH-1:0]    core_rd_addr;
  logic [DATA_WIDTH-1:0]    core_rd_data;

  logic                     ram_wr_en;
  logic [ADDR_WIDTH-1:0]    ram_wr_addr;
  logic [DATA_WIDTH-1:0]    ram_wr_data;
  logic [DATA_BYTE_NUM-1:0] ram_wr_byte_en;
  logic                     ram_write_ready;
  logic [ADDR_WIDTH-1:0]    ram_rd_addr;
  logic [DATA_WIDTH-1:0]    ram_rd_data;

  modport slave (
    input  core_wr_req, core_wr_addr, core_wr_data, core_wr_be,
    output core_wr_ack,
    input  fill_start, fill_base_addr, fill_valid, fill_data,
    output fill_ready, fill_busy, fill_done,
    input  core_rd_addr,
    output core_rd_data,
    output ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_byte_en,
    input  ram_write_ready,
    output ram_rd_addr,
    input  ram_rd_data
  );

  modport master (
    output core_wr_req, core_wr_addr, core_wr_data, core_wr_be,
    input  core_wr_ack,
    output fill_start, fill_base_addr, fill_valid, fill_data,
    input  fill_ready, fill_busy, fill_done,
    output core_rd_addr,
    input  core_rd_data,
    input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_wr_byte_en,
    output ram_write_ready,
    input  ram_rd_addr,
    output ram_rd_data
  );

endinterface

// File: rtl/cache_arb_fwd_merge.sv
// Byte-lane merge of a same-cycle RAM write over the returning read word.
module cache_arb_fwd_merge #(
  parameter int unsigned DATA_BYTE_NUM = 4
) (
  input  logic                       hit,
  input  logic [DATA_BYTE_NUM-1:0]   wr_be,
  input  logic [DATA_BYTE_NUM*8-1:0] wr_data,
  input  logic [DATA_BYTE_NUM*8-1:0] rd_data,
  output logic [DATA_BYTE_NUM*8-1:0] merged_data
);

  always_comb begin
    merged_data = rd_data;
    for (int unsigned i = 0; i < DATA_BYTE_NUM; i++) begin
      if (hit && wr_be[i]) merged_data[i*8 +: 8] = wr_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/cache_ram_arbiter.sv
// Shares the cache data RAM write port between core stores and line refills.
// Optional write-to-read forwarding: define CACHE_RAM_ARB_FWD_EN.
module cache_ram_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned DATA_BYTE_NUM = 4,
  parameter int unsigned LINE_WORDS    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_ram_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = LINE_IDX_W(LINE_WORDS);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(LINE_WORDS - 1);

  arb_state_e               state, state_next;
  logic                     fill_pend, pend_next;
  logic [IDX_W-1:0]         count, count_next;
  logic [ADDR_WIDTH-1:0]    base;
  logic                     fill_active;
  logic                     start_ok;
  logic                     write_done;

  logic                     wr_issue;
  logic [ADDR_WIDTH-1:0]    wr_addr_next;
  logic [DATA_WIDTH-1:0]    wr_data_next;
  logic [DATA_BYTE_NUM-1:0] wr_be_next;

  logic                     wr_en_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic [DATA_BYTE_NUM-1:0] wr_be_q;

  logic                     ack;
  logic                     ready;
  logic                     done;

  // Writes are issued back-to-back during a burst, so a write_ready seen while a
  // write is still on the port belongs to the previous write, not the awaited one.
  assign write_done  = bus.ram_write_ready & ~wr_en_q;
  assign fill_active = (state == FILL) || (state == FILL_WAIT);
  assign start_ok    = bus.fill_start & ~fill_active & ~fill_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      fill_pend <= 1'b0;
      count     <= '0;
    end else begin
      state     <= state_next;
      fill_pend <= pend_next;
      count     <= count_next;
    end
  end

  always_comb begin
    state_next   = state;
    pend_next    = fill_pend;
    count_next   = count;
    wr_issue     = 1'b0;
    wr_addr_next = wr_addr_q;
    wr_data_next = wr_data_q;
    wr_be_next   = wr_be_q;
    ack          = 1'b0;
    ready        = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok || fill_pend) begin
          count_next = '0;
          pend_next  = 1'b0;
          state_next = FILL;
        end else if (bus.core_wr_req) begin
          wr_issue     = 1'b1;
          wr_addr_next = bus.core_wr_addr;
          wr_data_next = bus.core_wr_data;
          wr_be_next   = bus.core_wr_be;
          state_next   = CORE_WAIT;
        end
      end
      CORE_WAIT: begin
        if (start_ok) pend_next = 1'b1;
        if (write_done) begin
          ack        = 1'b1;
          state_next = IDLE;
        end
      end
      FILL: begin
        ready = 1'b1;
        if (bus.fill_valid) begin
          wr_issue     = 1'b1;
          wr_addr_next = base + ADDR_WIDTH'(count);
          wr_data_next = bus.fill_data;
          wr_be_next   = '1;
          count_next   = count + 1'b1;
          if (count == LAST_IDX) state_next = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (write_done) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      if (start_ok) base <= bus.fill_base_addr & ALIGN_MASK;
      wr_en_q <= wr_issue;
      if (wr_issue) begin
        wr_addr_q <= wr_addr_next;
        wr_data_q <= wr_data_next;
        wr_be_q   <= wr_be_next;
      end
    end
  end

  assign bus.ram_wr_en      = wr_en_q;
  assign bus.ram_wr_addr    = wr_addr_q;
  assign bus.ram_wr_data    = wr_data_q;
  assign bus.ram_wr_byte_en = wr_be_q;
  assign bus.core_wr_ack    = ack;
  assign bus.fill_ready     = ready;
  assign bus.fill_done      = done;
  assign bus.fill_busy      = fill_active | fill_pend | bus.fill_start;
  assign bus.ram_rd_addr    = bus.core_rd_addr;

`ifdef CACHE_RAM_ARB_FWD_EN
  logic                     fwd_hit_q;
  logic [DATA_WIDTH-1:0]    fwd_data_q;
  logic [DATA_BYTE_NUM-1:0] fwd_be_q;
  logic [DATA_WIDTH-1:0]    rd_merged;

  // The read address is compared against the live write when registered, so
  // only the hit flag and the write lanes need to survive to the data cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
    end else begin
      fwd_hit_q  <= wr_en_q && (wr_addr_q == bus.core_rd_addr);
      fwd_data_q <= wr_data_q;
      fwd_be_q   <= wr_be_q;
    end
  end

  cache_arb_fwd_merge #(
    .DATA_BYTE_NUM(DATA_BYTE_NUM)
  ) u_fwd_merge (
    .hit         (fwd_hit_q),
    .wr_be       (fwd_be_q),
    .wr_data     (fwd_data_q),
    .rd_data     (bus.ram_rd_data),
    .merged_data (rd_merged)
  );

  assign bus.core_rd_data = rd_merged;
`else
  assign bus.core_rd_data = bus.ram_rd_data;
`endif

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Directed plus randomized bench for cache_ram_arbiter with a behavioural RAM
// and a write-order / memory-image reference model.
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))

module tb_cache_ram_arbiter;
  import cache_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned BN = 4;
  localparam int unsigned LW = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BN-1:0] be;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ram_clear;
  int   checks = 0;
  int   failures = 0;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] beat_data [LW];
  wr_t obs_q[$];
  wr_t exp_q[$];

  always #5 clk = ~clk;

  cache_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BYTE_NUM(BN)) bus ();

  cache_ram_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_BYTE_NUM(BN), .LINE_WORDS(LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte-enabled RAM, read-before-write, write_ready one cycle after the write.
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (bus.ram_wr_en) begin
      for (int b = 0; b < int'(BN); b++)
        if (bus.ram_wr_byte_en[b]) mem[bus.ram_wr_addr][b*8 +: 8] <= bus.ram_wr_data[b*8 +: 8];
    end
    bus.ram_write_ready <= bus.ram_wr_en;
    bus.ram_rd_data     <= mem[bus.ram_rd_addr];
  end

  always @(posedge clk) begin
    if (bus.ram_wr_en) obs_q.push_back(wr_t'{bus.ram_wr_addr, bus.ram_wr_data, bus.ram_wr_byte_en});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                                input logic [BN-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < int'(BN); b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic expect_fill(input logic [AW-1:0] base);
    int unsigned line;
    line = (int'(base) / LW) * LW;
    for (int unsigned i = 0; i < LW; i++)
      exp_q.push_back(wr_t'{AW'(line + i), beat_data[i], FULL_BE});
  endtask

  task automatic compare_writes(input string tag);
    `CHK({tag, "_count"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) `CHK({tag, "_write"}, obs_q[i], exp_q[i]);
      ref_mem[exp_q[i].addr] = merge_bytes(ref_mem[exp_q[i].addr], exp_q[i].data, exp_q[i].be);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic start_fill(input logic [AW-1:0] base);
    bus.fill_start     = 1'b1;
    bus.fill_base_addr = base;
    #1;
    `CHK("busy_on_start", bus.fill_busy, 1'b1);
    tick();
    bus.fill_start = 1'b0;
  endtask

  task automatic feed_beats(input int unsigned nbeats, input bit gapped, input bit expect_done);
    int n;
    for (int unsigned i = 0; i < nbeats; i++) begin
      if (gapped) begin
        bus.fill_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.fill_valid = 1'b1;
      bus.fill_data  = beat_data[i];
      n = 0;
      while (!bus.fill_ready && n < 40) begin
        tick();
        n++;
      end
      `CHK("fill_ready", bus.fill_ready, 1'b1);
      `CHK("busy_in_burst", bus.fill_busy, 1'b1);
      tick();
    end
    bus.fill_valid = 1'b0;
    if (expect_done) begin
      `CHK("ready_after_last", bus.fill_ready, 1'b0);
      `CHK("last_wr_en", bus.ram_wr_en, 1'b1);
      `CHK("done_early", bus.fill_done, 1'b0);
      tick();
      `CHK("done_pulse", bus.fill_done, 1'b1);
      `CHK("busy_at_done", bus.fill_busy, 1'b1);
      tick();
      `CHK("done_clear", bus.fill_done, 1'b0);
      `CHK("busy_clear", bus.fill_busy, 1'b0);
    end
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (!bus.core_wr_ack && n < 60) begin
      tick();
      n++;
    end
    `CHK("ack_seen", bus.core_wr_ack, 1'b1);
    bus.core_wr_req = 1'b0;
    tick();
    `CHK("ack_pulse", bus.core_wr_ack, 1'b0);
  endtask

  task automatic set_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BN-1:0] be);
    bus.core_wr_req  = 1'b1;
    bus.core_wr_addr = a;
    bus.core_wr_data = d;
    bus.core_wr_be   = be;
  endtask

  task automatic check_idle_outputs(input string tag);
    `CHK({tag, "_wr_en"}, bus.ram_wr_en, 1'b0);
    `CHK({tag, "_wr_addr"}, bus.ram_wr_addr, 0);
    `CHK({tag, "_wr_data"}, bus.ram_wr_data, 0);
    `CHK({tag, "_wr_be"}, bus.ram_wr_byte_en, 0);
    `CHK({tag, "_ack"}, bus.core_wr_ack, 1'b0);
    `CHK({tag, "_ready"}, bus.fill_ready, 1'b0);
    `CHK({tag, "_busy"}, bus.fill_busy, 1'b0);
    `CHK({tag, "_done"}, bus.fill_done, 1'b0);
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BN-1:0] be;
    logic [AW-1:0] fb;
    logic [DW-1:0] fwd_exp;
    bit saw_done;

    ram_clear          = 1'b1;
    bus.core_wr_req    = 1'b0;
    bus.core_wr_addr   = '0;
    bus.core_wr_data   = '0;
    bus.core_wr_be     = '0;
    bus.fill_start     = 1'b0;
    bus.fill_base_addr = '0;
    bus.fill_valid     = 1'b0;
    bus.fill_data      = '0;
    bus.core_rd_addr   = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

    tick();
    tick();
    check_idle_outputs("reset");
    rst_n     = 1'b1;
    ram_clear = 1'b0;
    tick();

    // Single store with exact latency, then readback.
    set_store(5'h05, 32'hDEADBEEF, 4'b0011);
    tick();
    checks++;
    if (bus.ram_wr_en !== 1'b1) begin
      failures++;
      $error("FAIL store_wr_en: observed=%0h", bus.ram_wr_en);
    end
    checks++;
    if (bus.ram_wr_addr !== 5'h05) begin
      failures++;
      $error("FAIL store_wr_addr: observed=%0h", bus.ram_wr_addr);
    end
    checks++;
    if (bus.ram_wr_data !== 32'hDEADBEEF) begin
      failures++;
      $error("FAIL store_wr_data: observed=%0h", bus.ram_wr_data);
    end
    checks++;
    if (bus.ram_wr_byte_en !== 4'b0011) begin
      failures++;
      $error("FAIL store_wr_be: observed=%0h", bus.ram_wr_byte_en);
    end
    checks++;
    if (bus.core_wr_ack !== 1'b0) begin
      failures++;
      $error("FAIL store_no_early_ack: observed=%0h", bus.core_wr_ack);
    end
    tick();
    checks++;
    if (bus.core_wr_ack !== 1'b1) begin
      failures++;
      $error("FAIL store_ack: observed=%0h", bus.core_wr_ack);
    end
    checks++;
    if (bus.ram_wr_en !== 1'b0) begin
      failures++;
      $error("FAIL store_wr_en_pulse: observed=%0h", bus.ram_wr_en);
    end
    bus.core_wr_req = 1'b0;
    bus.core_rd_addr = 5'h05;
    tick();
    checks++;
    if (bus.core_wr_ack !== 1'b0) begin
      failures++;
      $error("FAIL store_ack_pulse: observed=%0h", bus.core_wr_ack);
    end
    checks++;
    if (bus.core_rd_data !== 32'h0000BEEF) begin
      failures++;
      $error("FAIL store_readback: observed=%0h", bus.core_rd_data);
    end
    exp_q.push_back(wr_t'{5'h05, 32'hDEADBEEF, 4'b0011});
    compare_writes("store");

    // Refill with unaligned base.
    beat_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    expect_fill(5'h0B);
    start_fill(5'h0B);
    feed_beats(LW, 1'b0, 1'b1);
    compare_writes("refill");

    // Refill and store in the same cycle: burst first, then the store.
    beat_data = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
    expect_fill(5'h08);
    exp_q.push_back(wr_t'{5'h09, 32'hCAFEF00D, 4'hF});
    set_store(5'h09, 32'hCAFEF00D, 4'hF);
    start_fill(5'h08);
    feed_beats(LW, 1'b0, 1'b1);
    wait_ack();
    compare_writes("collision");

    // Refill requested during a store is deferred; a second start while busy is dropped.
    beat_data = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
    exp_q.push_back(wr_t'{5'h07, 32'h77777777, 4'hF});
    expect_fill(5'h12);
    set_store(5'h07, 32'h77777777, 4'hF);
    tick();
    start_fill(5'h12);
    wait_ack();
    start_fill(5'h18);
    feed_beats(LW, 1'b0, 1'b1);
    compare_writes("pending");

    // Reset in the middle of a burst.
    beat_data = '{32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003, 32'h5A5A0004};
    exp_q.push_back(wr_t'{5'h14, 32'h5A5A0001, FULL_BE});
    start_fill(5'h14);
    feed_beats(2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midburst_reset");
    tick();
    tick();
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      tick();
      saw_done = saw_done | bus.fill_done;
    end
    `CHK("no_done_after_reset", saw_done, 1'b0);
    `CHK("idle_after_reset", bus.fill_busy, 1'b0);
    compare_writes("reset_abandon");
    exp_q.push_back(wr_t'{5'h02, 32'h0BADF00D, 4'b1100});
    set_store(5'h02, 32'h0BADF00D, 4'b1100);
    wait_ack();
    compare_writes("store_after_reset");

    // Read of the address being written in the same cycle.
    exp_q.push_back(wr_t'{5'h03, 32'h11223344, 4'hF});
    set_store(5'h03, 32'h11223344, 4'hF);
    wait_ack();
    compare_writes("fwd_prep");
    set_store(5'h03, 32'h000000A5, 4'b0001);
    tick();
    `CHK("fwd_wr_en", bus.ram_wr_en, 1'b1);
    bus.core_rd_addr = 5'h03;
    tick();
`ifdef CACHE_RAM_ARB_FWD_EN
    fwd_exp = 32'h112233A5;
`else
    fwd_exp = 32'h11223344;
`endif
    `CHK("fwd_same_cycle_read", bus.core_rd_data, fwd_exp);
    `CHK("fwd_ack", bus.core_wr_ack, 1'b1);
    bus.core_wr_req = 1'b0;
    tick();
    `CHK("fwd_later_read", bus.core_rd_data, 32'h112233A5);
    exp_q.push_back(wr_t'{5'h03, 32'h000000A5, 4'b0001});
    compare_writes("fwd");

    // Randomized mix of stores, refills, collisions and reads.
    for (int it = 0; it < 30; it++) begin
      a  = AW'($urandom);
      d  = $urandom;
      be = BN'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          exp_q.push_back(wr_t'{a, d, be});
          set_store(a, d, be);
          wait_ack();
          compare_writes("rnd_store");
        end
        1: begin
          for (int unsigned i = 0; i < LW; i++) beat_data[i] = $urandom;
          expect_fill(a);
          start_fill(a);
          feed_beats(LW, 1'b1, 1'b1);
          compare_writes("rnd_fill");
        end
        2: begin
          for (int unsigned i = 0; i < LW; i++) beat_data[i] = $urandom;
          fb = AW'($urandom);
          expect_fill(fb);
          exp_q.push_back(wr_t'{a, d, be});
          set_store(a, d, be);
          start_fill(fb);
          feed_beats(LW, 1'($urandom_range(0, 1)), 1'b1);
          wait_ack();
          compare_writes("rnd_collision");
        end
        default: begin
          bus.core_rd_addr = a;
          tick();
          `CHK("rnd_read", bus.core_rd_data, ref_mem[a]);
        end
      endcase
      tick();
    end

    // Full memory image against the reference.
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.core_rd_addr = AW'(i);
      tick();
      checks++;
      if (bus.core_rd_data !== ref_mem[i]) begin
        failures++;
        $error("FAIL final_image[%0d]: observed=%0h expected=%0h", i, bus.core_rd_data, ref_mem[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_ram_arbiter.md
Name: cache_ram_arbiter

Overview:
- Owns the single write port of the cache data RAM (1 read + 1 byte-enabled write port, 1-cycle read latency, `write_ready` pulse one cycle after each write).
- Shares that write port between the core store path and the line-refill engine.
- Sequences refill bursts as LINE_WORDS consecutive full-word writes.
- Passes the core read port through to the RAM, with optional write-to-read forwarding.

Parameters:
- DATA_WIDTH, 32, word width; must equal DATA_BYTE_NUM*8.
- ADDR_WIDTH, 5, RAM word-address width.
- DATA_BYTE_NUM, 4, byte lanes per word.
- LINE_WORDS, 4, refill burst length; power of 2, 2..2^ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- core_wr_req  in  1  core store request; held until core_wr_ack.
- core_wr_addr  in  ADDR_WIDTH  store word address.
- core_wr_data  in  DATA_WIDTH  store data.
- core_wr_be  in  DATA_BYTE_NUM  store byte enables.
- core_wr_ack  out  1  1-cycle pulse: store committed.
- fill_start  in  1  1-cycle pulse: begin refill; ignored while fill_busy=1.
- fill_base_addr  in  ADDR_WIDTH  line base; low log2(LINE_WORDS) bits forced to 0.
- fill_valid  in  1  refill beat valid.
- fill_data  in  DATA_WIDTH  refill beat data.
- fill_ready  out  1  refill beat accepted when fill_valid & fill_ready.
- fill_busy  out  1  refill accepted/pending and not yet done.
- fill_done  out  1  1-cycle pulse: last refill beat committed.
- core_rd_addr  in  ADDR_WIDTH  core read address.
- core_rd_data  out  DATA_WIDTH  read data, one cycle after core_rd_addr.
- ram_wr_en  out  1  to RAM wr_en.
- ram_wr_addr  out  ADDR_WIDTH  to RAM wr_addr.
- ram_wr_data  out  DATA_WIDTH  to RAM wr_data.
- ram_wr_byte_en  out  DATA_BYTE_NUM  to RAM wr_byte_en.
- ram_write_ready  in  1  from RAM write_ready.
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr; combinational copy of core_rd_addr.
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data.

Behaviour:
- Reset: every output 0; state IDLE; fill_pend=0; beat counter 0. Reset mid-burst or mid-store abandons the operation silently; no ack and no done are issued.
- All ram_wr_* outputs are registered; at most one RAM write is issued per cycle.
- States: IDLE, CORE_WAIT, FILL, FILL_WAIT.
- IDLE:
  - If fill_start or fill_pend: latch base, count=0, clear fill_pend, go to FILL.
  - Else if core_wr_req: register addr/data/be, pulse ram_wr_en next cycle, go to CORE_WAIT.
  - Refill has strict priority over a simultaneous core store.
- CORE_WAIT:
  - Wait for ram_write_ready.
  - In that cycle core_wr_ack=1 (combinational from state and ram_write_ready), then go to IDLE.
  - Store latency: req cycle T → ram_wr_en at T+1 → ack at T+2.
  - Core deasserts or replaces req in the cycle after ack; a held req is treated as a new store.
- fill_start arriving in CORE_WAIT sets fill_pend; fill_busy=1 from the fill_start cycle until fill_done.
- FILL:
  - fill_ready=1.
  - Each accepted beat drives, next cycle: ram_wr_en=1, addr=base+count (wraps within ADDR_WIDTH), byte_en all ones.
  - count increments per beat.
  - Beats may be back-to-back or gapped.
  - On the LINE_WORDS-th beat: fill_ready drops the next cycle; go to FILL_WAIT.
  - core_wr_req is stalled for the whole burst.
- FILL_WAIT:
  - Wait for ram_write_ready of the last write.
  - fill_done=1 in that cycle; fill_busy drops with it; go to IDLE.
  - A core request pending at that point is served in the next IDLE cycle.
- Read path: ram_rd_addr=core_rd_addr; core_rd_data registered-through, 1-cycle latency, no arbitration (reads never stall).

Optional Feature:
- Macro: CACHE_RAM_ARB_FWD_EN.
- Defined: register the read address. If the RAM write issued in the same cycle as the read targets that address, core_rd_data merges the written bytes (per byte_en) over ram_rd_data, so the read returns post-write data.
- Undefined: core_rd_data = ram_rd_data unmodified; a same-cycle read returns pre-write data.

Decomposition:
- Package cache_arb_pkg: state enum (IDLE, CORE_WAIT, FILL, FILL_WAIT); function LINE_IDX_W = clog2(LINE_WORDS); localparam FULL_BE.
- One natural sub-module: cache_arb_fwd_merge, the byte-lane merge mux, instantiated only under CACHE_RAM_ARB_FWD_EN.

Test Plan:
- Single store: req addr 0x05, data 0xDEADBEEF, be 0b0011 at T → ram_wr_en at T+1 with those values, core_wr_ack at T+2 only; RAM readback word 5 = 0x0000BEEF from a zeroed RAM.
- Refill: fill_start base 0x0B (forced to 0x08), 4 back-to-back beats 0x11..0x44 → writes to 8,9,10,11 with be 0xF; fill_done one cycle after the last write; fill_busy high throughout.
- Collision: fill_start and core_wr_req in the same cycle → 4 fill writes first, then the core write, then core_wr_ack; core store never interleaves.
- Pending fill: fill_start during CORE_WAIT → ack first, then the burst starts; a second fill_start while busy is ignored (exactly 4 writes).
- Reset: assert rst_n low after 2 of 4 beats → all outputs 0 asynchronously; after release no fill_done, and the next core store completes normally.
- Forwarding: write 0xA5 to byte 0 of addr 3 with a same-cycle read of addr 3 → with CACHE_RAM_ARB_FWD_EN, data shows 0x..A5; without it, the old word is returned.
